key_search: RTL and testbench
=============================

Name: key_search

Overview:
- Brute-force key-search controller that sits directly downstream of arc4.
- Sweeps 24-bit candidate keys through arc4's en/rdy handshake.
- After each decryption, scans the length-prefixed plaintext memory that arc4 wrote and checks that every character is printable ASCII.
- Stops at the first key whose plaintext passes, or reports failure once the key range is exhausted.

Parameters:
- KEY_FIRST, 24'h000000, first candidate key.
- KEY_LAST, 24'hFFFFFF, last candidate key (inclusive).
- KEY_STEP, 1, key increment; 2 is used when two instances split the space (odd/even).
- ASCII_LO, 8'h20, lowest accepted plaintext byte.
- ASCII_HI, 8'h7E, highest accepted plaintext byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  start request; accepted only when rdy=1
- rdy  out  1  idle and ready to accept en
- key_valid  out  1  last search found a key
- key  out  24  found key (valid when key_valid=1)
- arc4_en  out  1  one-cycle start pulse to arc4
- arc4_rdy  in  1  arc4 idle/ready
- arc4_key  out  24  candidate key driven to arc4
- pt_addr  out  8  plaintext memory read address
- pt_rddata  in  8  plaintext read data; synchronous RAM, 1-cycle latency

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - rdy=1, key_valid=0, key=0, arc4_en=0, pt_addr=0.
  - arc4_key=KEY_FIRST; state=IDLE.
- Reset mid-search aborts to IDLE and clears all results. arc4 is not reset by this block.
- State machine:
  - IDLE: rdy=1. On en: clear key_valid and key, load cand=KEY_FIRST, go to LAUNCH. en is ignored in all other states.
  - LAUNCH: wait until arc4_rdy=1, then assert arc4_en for exactly one cycle (arc4_key=cand), then go to WAIT_BUSY.
  - WAIT_BUSY: wait for arc4_rdy=0, then go to WAIT_DONE. This guards against arc4 dropping rdy one cycle late.
  - WAIT_DONE: wait for arc4_rdy=1, then go to RD_LEN.
  - RD_LEN: pt_addr=0, go to LEN_WAIT.
  - LEN_WAIT: latch len=pt_rddata.
    - len=0 → FOUND (empty message passes).
    - Otherwise pt_addr=1 and go to SCAN.
  - SCAN: pipelined, one byte per cycle.
    - Each cycle, check the byte returned for the previous address while issuing the next address.
    - Byte < ASCII_LO or > ASCII_HI → NEXT immediately (early abort, no further reads).
    - Check of address len passes → FOUND.
    - pt_addr never exceeds len. len=255 scans addresses 1..255 with no wrap.
  - NEXT:
    - Compute cand+KEY_STEP at 25-bit width.
    - Result > KEY_LAST or bit 24 set → EXHAUSTED.
    - Otherwise update cand and go to LAUNCH.
  - FOUND: key=cand, key_valid=1, go to IDLE.
  - EXHAUSTED: key_valid=0, key=0, go to IDLE.
- rdy is deasserted from the cycle after en is accepted until the cycle IDLE is re-entered.
- key and key_valid hold until the next accepted en or rst.
- arc4_key holds cand stable from LAUNCH through the end of SCAN.
- KEY_FIRST > KEY_LAST: the single key KEY_FIRST is tried, then EXHAUSTED.
- Latency per candidate, excluding arc4 time: 1 (LAUNCH) + 2 (length read) + len + 1 cycles worst case.

Decomposition:
- Package arc4_pkg holds:
  - key_search state enum;
  - constant PT_LEN_ADDR=8'd0;
  - ASCII bound defaults, shared with arc4 benches.
- One natural sub-module: ascii_scan, which holds the length read plus the pipelined printable check.
  - Handshake: start/done/pass.
  - Owns pt_addr.
  - Reusable by a future two-core parallel cracker.

Test Plan:
- The bench uses a behavioural arc4 model (rdy low 20 cycles after en) and a 256x8 sync-RAM pt model.
- Correct key: model writes "\x05HELLO" only when key=24'h000003 (garbage with byte 0x01 otherwise); KEY_FIRST=0 → four arc4_en pulses, then key_valid=1, key=24'h000003, rdy=1.
- Exhaustion: KEY_LAST=24'h000004 and the model never produces printable text → exactly 5 arc4_en pulses, then key_valid=0, key=0.
- Boundary bytes:
  - len=3, bytes 8'h20, 8'h7E, 8'h41 → pass.
  - len=3, bytes 8'h1F or 8'h7F at position 2 → fail, with pt_addr never exceeding 3 (early abort checked).
- Length extremes:
  - len=0 → FOUND on first candidate.
  - len=255, all 8'h61 → pass; pt_addr max 255 with no wrap to 0.
- Handshake/reset:
  - en held high through the search → only one search.
  - rst pulsed while in WAIT_DONE → next cycle rdy=1, arc4_en=0, key_valid=0.
  - A new en after that waits for arc4_rdy before pulsing arc4_en.
- KEY_STEP=2, KEY_FIRST=1, KEY_LAST=24'hFFFFFF with no match → key after 24'hFFFFFF+2 overflow → EXHAUSTED, no wrap to 1.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and constants for the arc4 key-search slice.
// Holds FSM encodings, memory layout and ASCII bounds.
package arc4_pkg;

    localparam logic [7:0] PT_LEN_ADDR  = 8'd0;
    localparam logic [7:0] ASCII_LO_DEF = 8'h20;
    localparam logic [7:0] ASCII_HI_DEF = 8'h7E;

    typedef enum logic [2:0] {
        KS_IDLE,
        KS_LAUNCH,
        KS_WAIT_BUSY,
        KS_WAIT_DONE,
        KS_SCAN,
        KS_NEXT,
        KS_FOUND,
        KS_EXHAUSTED
    } ks_state_t;

    typedef enum logic [1:0] {
        SC_IDLE,
        SC_RD_LEN,
        SC_LEN_WAIT,
        SC_SCAN
    } sc_state_t;

    function automatic logic is_printable(
        input logic [7:0] b,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        return (b >= lo) && (b <= hi);
    endfunction

endpackage

// File: rtl/ascii_scan.sv
// Reads the length-prefixed plaintext and checks every byte
// is printable, one byte per cycle against a 1-cycle RAM.
module ascii_scan
    import arc4_pkg::*;
#(
    parameter logic [7:0] ASCII_LO = ASCII_LO_DEF,
    parameter logic [7:0] ASCII_HI = ASCII_HI_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       done,
    output logic       pass,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata
);

    sc_state_t  state;
    sc_state_t  state_nxt;
    logic [7:0] len;
    logic [7:0] len_nxt;
    logic [7:0] addr_nxt;
    logic [7:0] chk_addr;
    logic       byte_ok;

    assign byte_ok = is_printable(pt_rddata, ASCII_LO, ASCII_HI);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address, length and the address whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pt_addr  <= PT_LEN_ADDR;
            len      <= 8'd0;
            chk_addr <= PT_LEN_ADDR;
        end else begin
            pt_addr  <= addr_nxt;
            len      <= len_nxt;
            chk_addr <= pt_addr;
        end
    end

    // Next state: issue next address while checking the previous byte.
    always_comb begin
        state_nxt = state;
        addr_nxt  = pt_addr;
        len_nxt   = len;
        done      = 1'b0;
        pass      = 1'b0;
        case (state)
            SC_IDLE: begin
                if (start) begin
                    addr_nxt  = PT_LEN_ADDR;
                    state_nxt = SC_RD_LEN;
                end
            end
            SC_RD_LEN: begin
                state_nxt = SC_LEN_WAIT;
            end
            SC_LEN_WAIT: begin
                len_nxt = pt_rddata;
                if (pt_rddata == 8'd0) begin
                    done      = 1'b1;
                    pass      = 1'b1;
                    state_nxt = SC_IDLE;
                end else begin
                    addr_nxt  = 8'd1;
                    state_nxt = SC_SCAN;
                end
            end
            SC_SCAN: begin
                if (pt_addr != len) begin
                    addr_nxt = pt_addr + 8'd1;
                end
                if (chk_addr != PT_LEN_ADDR) begin
                    if (!byte_ok) begin
                        done      = 1'b1;
                        addr_nxt  = pt_addr;
                        state_nxt = SC_IDLE;
                    end else if (chk_addr == len) begin
                        done      = 1'b1;
                        pass      = 1'b1;
                        state_nxt = SC_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = SC_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/key_search.sv
// Brute-force key sweep driving arc4 and checking each
// decryption for printable plaintext.
module key_search
    import arc4_pkg::*;
#(
    parameter logic [23:0] KEY_FIRST = 24'h000000,
    parameter logic [23:0] KEY_LAST  = 24'hFFFFFF,
    parameter logic [23:0] KEY_STEP  = 24'd1,
    parameter logic [7:0]  ASCII_LO  = ASCII_LO_DEF,
    parameter logic [7:0]  ASCII_HI  = ASCII_HI_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    output logic        key_valid,
    output logic [23:0] key,
    output logic        arc4_en,
    input  logic        arc4_rdy,
    output logic [23:0] arc4_key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata
);

    ks_state_t   state;
    ks_state_t   state_nxt;
    logic [23:0] cand;
    logic [24:0] cand_sum;
    logic        cand_end;
    logic        scan_start;
    logic        scan_done;
    logic        scan_pass;

    assign cand_sum = {1'b0, cand} + {1'b0, KEY_STEP};
    assign cand_end = cand_sum[24] || (cand_sum[23:0] > KEY_LAST);
    assign rdy      = (state == KS_IDLE);
    assign arc4_key = cand;

    ascii_scan #(
        .ASCII_LO (ASCII_LO),
        .ASCII_HI (ASCII_HI)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .start     (scan_start),
        .done      (scan_done),
        .pass      (scan_pass),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= KS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Candidate and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand      <= KEY_FIRST;
            key       <= 24'd0;
            key_valid <= 1'b0;
        end else begin
            case (state)
                KS_IDLE: begin
                    if (en) begin
                        cand      <= KEY_FIRST;
                        key       <= 24'd0;
                        key_valid <= 1'b0;
                    end
                end
                KS_NEXT: begin
                    if (!cand_end) begin
                        cand <= cand_sum[23:0];
                    end
                end
                KS_FOUND: begin
                    key       <= cand;
                    key_valid <= 1'b1;
                end
                KS_EXHAUSTED: begin
                    key       <= 24'd0;
                    key_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state plus arc4 launch and scan start strobes.
    always_comb begin
        state_nxt  = state;
        arc4_en    = 1'b0;
        scan_start = 1'b0;
        case (state)
            KS_IDLE: begin
                if (en) begin
                    state_nxt = KS_LAUNCH;
                end
            end
            KS_LAUNCH: begin
                if (arc4_rdy) begin
                    arc4_en   = 1'b1;
                    state_nxt = KS_WAIT_BUSY;
                end
            end
            KS_WAIT_BUSY: begin
                if (!arc4_rdy) begin
                    state_nxt = KS_WAIT_DONE;
                end
            end
            KS_WAIT_DONE: begin
                if (arc4_rdy) begin
                    scan_start = 1'b1;
                    state_nxt  = KS_SCAN;
                end
            end
            KS_SCAN: begin
                if (scan_done) begin
                    state_nxt = scan_pass ? KS_FOUND : KS_NEXT;
                end
            end
            KS_NEXT: begin
                state_nxt = cand_end ? KS_EXHAUSTED : KS_LAUNCH;
            end
            KS_FOUND: begin
                state_nxt = KS_IDLE;
            end
            KS_EXHAUSTED: begin
                state_nxt = KS_IDLE;
            end
            default: begin
                state_nxt = KS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_key_search.sv
// Bench for key_search: arc4 and plaintext RAM models plus
// a search-level reference model and per-cycle checks.
module tb_key_search;

    localparam int TMO      = 3000;
    localparam int M_HELLO  = 0;
    localparam int M_GARB   = 1;
    localparam int M_BOUND  = 2;
    localparam int M_BAD1F  = 3;
    localparam int M_BAD7F  = 4;
    localparam int M_LEN0   = 5;
    localparam int M_LEN255 = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  en_v = 3'b000;
    logic [2:0]  rdy_v;
    logic [2:0]  kv_v;
    logic [2:0]  a4en_v;
    logic [2:0]  a4rdy_v = 3'b111;
    logic [23:0] key_v [3];
    logic [23:0] a4key_v [3];
    logic [7:0]  pa_v [3];
    logic [7:0]  prd_v [3];

    int          mode [3];
    logic [23:0] cur_key [3];
    int          busy [3];
    int          en_cnt [3];
    int          maxpa [3];
    bit          scanning [3];
    bit          wrap [3];
    logic [7:0]  prev_pa [3];
    bit          exp_ok [3];
    bit          exp_found [3];
    logic [23:0] exp_key [3];
    bit          armed = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    key_search u0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .rdy(rdy_v[0]),
        .key_valid(kv_v[0]), .key(key_v[0]),
        .arc4_en(a4en_v[0]), .arc4_rdy(a4rdy_v[0]),
        .arc4_key(a4key_v[0]), .pt_addr(pa_v[0]),
        .pt_rddata(prd_v[0])
    );

    key_search #(.KEY_LAST(24'h000004)) u1 (
        .clk(clk), .rst(rst), .en(en_v[1]), .rdy(rdy_v[1]),
        .key_valid(kv_v[1]), .key(key_v[1]),
        .arc4_en(a4en_v[1]), .arc4_rdy(a4rdy_v[1]),
        .arc4_key(a4key_v[1]), .pt_addr(pa_v[1]),
        .pt_rddata(prd_v[1])
    );

    key_search #(
        .KEY_FIRST(24'hFFFFFB),
        .KEY_STEP(24'd2)
    ) u2 (
        .clk(clk), .rst(rst), .en(en_v[2]), .rdy(rdy_v[2]),
        .key_valid(kv_v[2]), .key(key_v[2]),
        .arc4_en(a4en_v[2]), .arc4_rdy(a4rdy_v[2]),
        .arc4_key(a4key_v[2]), .pt_addr(pa_v[2]),
        .pt_rddata(prd_v[2])
    );

    function automatic logic [24:0] p_first(input int i);
        return (i == 2) ? 25'h0FFFFFB : 25'h0;
    endfunction

    function automatic logic [24:0] p_last(input int i);
        return (i == 1) ? 25'h0000004 : 25'h0FFFFFF;
    endfunction

    function automatic logic [24:0] p_step(input int i);
        return (i == 2) ? 25'd2 : 25'd1;
    endfunction

    // Plaintext content arc4 leaves behind for a given key.
    function automatic logic [7:0] byte_at(
        input int m, input logic [23:0] k, input logic [7:0] a
    );
        logic [7:0] b;
        b = 8'h00;
        case (m)
            M_HELLO: begin
                if (k == 24'd3) begin
                    case (a)
                        8'd0: b = 8'd5;
                        8'd1: b = 8'h48;
                        8'd2: b = 8'h45;
                        8'd3: b = 8'h4C;
                        8'd4: b = 8'h4C;
                        8'd5: b = 8'h4F;
                        default: b = 8'h00;
                    endcase
                end else begin
                    b = (a <= 8'd1) ? 8'h01 : 8'h00;
                end
            end
            M_GARB: b = (a <= 8'd1) ? 8'h01 : 8'h00;
            M_BOUND: begin
                case (a)
                    8'd0: b = 8'd3;
                    8'd1: b = 8'h20;
                    8'd2: b = 8'h7E;
                    8'd3: b = 8'h41;
                    default: b = 8'h00;
                endcase
            end
            M_BAD1F, M_BAD7F: begin
                case (a)
                    8'd0: b = 8'd3;
                    8'd1: b = 8'h41;
                    8'd2: begin
                        if (k != 24'd0) b = 8'h42;
                        else if (m == M_BAD1F) b = 8'h1F;
                        else b = 8'h7F;
                    end
                    8'd3: b = 8'h43;
                    default: b = 8'h00;
                endcase
            end
            M_LEN255: b = (a == 8'd0) ? 8'hFF : 8'h61;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic bit passes(input int m, input logic [23:0] k);
        int n;
        logic [7:0] b;
        n = int'(byte_at(m, k, 8'd0));
        for (int a = 1; a <= n; a++) begin
            b = byte_at(m, k, 8'(a));
            if (b < 8'h20 || b > 8'h7E) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Search outcome: first passing key in the sweep, or none.
    task automatic predict(
        input int m, input int i,
        output bit found, output logic [23:0] fk, output int tries
    );
        logic [24:0] c;
        c = p_first(i);
        found = 1'b0;
        fk = 24'd0;
        tries = 0;
        for (int n = 0; n < 64; n++) begin
            tries++;
            if (passes(m, c[23:0])) begin
                found = 1'b1;
                fk = c[23:0];
                return;
            end
            c = c + p_step(i);
            if (c[24] || c > p_last(i)) return;
        end
    endtask

    task automatic check(
        input string name, input logic [31:0] act, input logic [31:0] req
    );
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // arc4 model (busy 20 cycles per launch) and sync plaintext RAM.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            prd_v[i] <= byte_at(mode[i], cur_key[i], pa_v[i]);
            if (a4en_v[i] && a4rdy_v[i]) begin
                cur_key[i] <= a4key_v[i];
                busy[i]    <= 20;
                a4rdy_v[i] <= 1'b0;
            end else if (busy[i] > 0) begin
                busy[i] <= busy[i] - 1;
                if (busy[i] == 1) a4rdy_v[i] <= 1'b1;
            end
        end
    end

    // Per-cycle compare against the model expectations.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                check("launch_while_busy",
                      32'(a4en_v[i] & ~a4rdy_v[i]), 32'd0);
                if (!a4rdy_v[i])
                    check("arc4_key_hold", 32'(a4key_v[i]),
                          32'(cur_key[i]));
                if (rdy_v[i] && exp_ok[i]) begin
                    check("idle_key_valid", 32'(kv_v[i]),
                          32'(exp_found[i]));
                    check("idle_key", 32'(key_v[i]), 32'(exp_key[i]));
                end
                if (!rdy_v[i]) begin
                    check("busy_key_valid", 32'(kv_v[i]), 32'd0);
                    check("busy_key", 32'(key_v[i]), 32'd0);
                end
                if (a4en_v[i]) begin
                    check("cand_seq", 32'(a4key_v[i]),
                          32'(24'(p_first(i) + p_step(i) * 25'(en_cnt[i]))));
                    en_cnt[i]++;
                    scanning[i] = 1'b0;
                end else if (!rdy_v[i] && pa_v[i] == 8'd0) begin
                    scanning[i] = 1'b1;
                end
                if (scanning[i] && int'(pa_v[i]) > maxpa[i])
                    maxpa[i] = int'(pa_v[i]);
                if (!rdy_v[i] && prev_pa[i] == 8'hFF && pa_v[i] == 8'h00)
                    wrap[i] = 1'b1;
                prev_pa[i] = pa_v[i];
            end
        end
    end

    task automatic clear_exp();
        for (int i = 0; i < 3; i++) begin
            exp_found[i] = 1'b0;
            exp_key[i]   = 24'd0;
            exp_ok[i]    = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_exp();
    endtask

    task automatic run_search(
        input int i, input int m, input bit hold, input string tag
    );
        bit f;
        logic [23:0] fk;
        int tr;
        int t;
        mode[i] = m;
        predict(m, i, f, fk, tr);
        t = 0;
        while (!rdy_v[i] && t < 100) begin
            tick();
            t++;
        end
        en_cnt[i] = 0;
        maxpa[i] = 0;
        wrap[i] = 1'b0;
        scanning[i] = 1'b0;
        exp_ok[i] = 1'b0;
        en_v[i] = 1'b1;
        tick();
        if (!hold) en_v[i] = 1'b0;
        t = 0;
        while (!rdy_v[i] && t < TMO) begin
            tick();
            t++;
        end
        en_v[i] = 1'b0;
        check({tag, "_done"}, 32'(rdy_v[i]), 32'd1);
        exp_found[i] = f;
        exp_key[i] = f ? fk : 24'd0;
        exp_ok[i] = 1'b1;
        check({tag, "_tries"}, 32'(en_cnt[i]), 32'(tr));
        check({tag, "_key_valid"}, 32'(kv_v[i]), 32'(f));
        check({tag, "_key"}, 32'(key_v[i]), 32'(exp_key[i]));
    endtask

    task automatic pin_model();
        bit f;
        logic [23:0] fk;
        int tr;
        predict(M_HELLO, 0, f, fk, tr);
        check("model_hello_tries", 32'(tr), 32'd4);
        check("model_hello_key", 32'(fk), 32'd3);
        predict(M_GARB, 1, f, fk, tr);
        check("model_exh_tries", 32'(tr), 32'd5);
        check("model_exh_found", 32'(f), 32'd0);
        predict(M_GARB, 2, f, fk, tr);
        check("model_step2_tries", 32'(tr), 32'd3);
        predict(M_BAD7F, 0, f, fk, tr);
        check("model_bad_key", 32'(fk), 32'd1);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 3; i++) begin
            mode[i] = M_GARB;
            cur_key[i] = 24'd0;
            busy[i] = 0;
            en_cnt[i] = 0;
            maxpa[i] = 0;
            scanning[i] = 1'b0;
            wrap[i] = 1'b0;
            prev_pa[i] = 8'd0;
        end
        clear_exp();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            check("rst_rdy", 32'(rdy_v[i]), 32'd1);
            check("rst_key_valid", 32'(kv_v[i]), 32'd0);
            check("rst_key", 32'(key_v[i]), 32'd0);
            check("rst_arc4_en", 32'(a4en_v[i]), 32'd0);
            check("rst_pt_addr", 32'(pa_v[i]), 32'd0);
            check("rst_arc4_key", 32'(a4key_v[i]),
                  32'(24'(p_first(i))));
        end
        armed = 1'b1;
        pin_model();

        run_search(1, M_GARB, 1'b0, "exh");
        check("exh_pulses", 32'(en_cnt[1]), 32'd5);
        run_search(2, M_GARB, 1'b0, "step2");
        check("step2_pulses", 32'(en_cnt[2]), 32'd3);
        check("step2_key_valid", 32'(kv_v[2]), 32'd0);

        do_reset();
        run_search(0, M_HELLO, 1'b0, "hello");
        check("hello_pulses", 32'(en_cnt[0]), 32'd4);
        check("hello_key_lit", 32'(key_v[0]), 32'h000003);

        do_reset();
        run_search(0, M_BOUND, 1'b0, "bound");
        check("bound_maxaddr", 32'(maxpa[0]), 32'd3);

        do_reset();
        run_search(0, M_BAD1F, 1'b0, "bad1f");
        check("bad1f_addr_le3", 32'(maxpa[0] <= 3), 32'd1);
        check("bad1f_key_lit", 32'(key_v[0]), 32'd1);

        do_reset();
        run_search(0, M_BAD7F, 1'b0, "bad7f");
        check("bad7f_addr_le3", 32'(maxpa[0] <= 3), 32'd1);

        do_reset();
        run_search(0, M_LEN0, 1'b1, "len0_hold");
        repeat (5) tick();
        check("hold_one_search", 32'(en_cnt[0]), 32'd1);
        check("hold_rdy", 32'(rdy_v[0]), 32'd1);

        do_reset();
        run_search(0, M_LEN255, 1'b0, "len255");
        check("len255_maxaddr", 32'(maxpa[0]), 32'd255);
        check("len255_nowrap", 32'(wrap[0]), 32'd0);

        do_reset();
        mode[0] = M_HELLO;
        exp_ok[0] = 1'b0;
        en_cnt[0] = 0;
        en_v[0] = 1'b1;
        tick();
        en_v[0] = 1'b0;
        t = 0;
        while (a4rdy_v[0] && t < 50) begin
            tick();
            t++;
        end
        check("abort_arc4_busy", 32'(a4rdy_v[0]), 32'd0);
        repeat (5) tick();
        do_reset();
        check("abort_rdy", 32'(rdy_v[0]), 32'd1);
        check("abort_arc4_en", 32'(a4en_v[0]), 32'd0);
        check("abort_key_valid", 32'(kv_v[0]), 32'd0);
        check("abort_arc4_still_busy", 32'(a4rdy_v[0]), 32'd0);
        run_search(0, M_HELLO, 1'b0, "post_rst");
        check("post_rst_key_lit", 32'(key_v[0]), 32'h000003);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
